// File: rtl/sound_duration_timer.sv
// Duration timer answering audio sound requests with a one-cycle time_done pulse,
// plus a square-wave tone generator. Define TONE_GATE_EN to gate the tone by busy.
module sound_duration_timer #(
    parameter int unsigned TICK_DIV   = 5000000,
    parameter int unsigned HALF_SHOT  = 56818,
    parameter int unsigned HALF_HIT   = 113636,
    parameter int unsigned HALF_ENEMY = 75757
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       request_time,
    input  logic [3:0] time_amount,
    input  logic [3:0] sound_key,
    output logic       time_done,
    output logic       busy,
    output logic       audio_out
);
    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [16:0]   SHOT_LAST  = 17'(HALF_SHOT - 1);
    localparam logic [16:0]   HIT_LAST   = 17'(HALF_HIT - 1);
    localparam logic [16:0]   ENEMY_LAST = 17'(HALF_ENEMY - 1);

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]    remaining_q, remaining_d;
    logic          busy_q, busy_d;
    logic          time_done_q, time_done_d;
    logic [3:0]    key_q, key_d;
    logic [16:0]   tone_cnt_q, tone_cnt_d;
    logic          audio_q, audio_d;
    logic [16:0]   half_last;
    logic          tone_on;
    logic          tone_run;

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        remaining_d = remaining_q;
        case (state_q)
            // S_DONE accepts a new request exactly like S_IDLE
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (request_time && time_amount != '0) begin
                    state_d     = S_COUNT;
                    remaining_d = time_amount;
                    tick_cnt_d  = '0;
                end
            end
            S_COUNT: begin
                if (request_time) begin
                    if (time_amount != '0) begin
                        remaining_d = time_amount;
                        tick_cnt_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (tick_cnt_q == TICK_LAST) begin
                    tick_cnt_d  = '0;
                    remaining_d = remaining_q - 4'd1;
                    if (remaining_q == 4'd1) begin
                        state_d = S_DONE;
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d      = (state_d == S_COUNT);
        time_done_d = (state_d == S_DONE);
    end

    always_comb begin
        key_d      = sound_key;
        tone_cnt_d = '0;
        audio_d    = 1'b0;
        half_last  = '0;
        tone_on    = 1'b0;
        case (key_q)
            4'd1: begin half_last = SHOT_LAST;  tone_on = 1'b1; end
            4'd2: begin half_last = HIT_LAST;   tone_on = 1'b1; end
            4'd3: begin half_last = ENEMY_LAST; tone_on = 1'b1; end
            default: ;
        endcase
`ifdef TONE_GATE_EN
        tone_run = tone_on && (sound_key == key_q) && busy_q;
`else
        tone_run = tone_on && (sound_key == key_q);
`endif
        // A key change restarts the tone from a clean low phase
        if (tone_run) begin
            if (tone_cnt_q == half_last) begin
                tone_cnt_d = '0;
                audio_d    = ~audio_q;
            end else begin
                tone_cnt_d = tone_cnt_q + 17'd1;
                audio_d    = audio_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tick_cnt_q  <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            time_done_q <= 1'b0;
            key_q       <= 4'd15;
            tone_cnt_q  <= '0;
            audio_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            time_done_q <= time_done_d;
            key_q       <= key_d;
            tone_cnt_q  <= tone_cnt_d;
            audio_q     <= audio_d;
        end
    end

    assign busy      = busy_q;
    assign time_done = time_done_q;
    assign audio_out = audio_q;

endmodule

// File: tb/tb_sound_duration_timer.sv
// Directed bench for sound_duration_timer with TICK_DIV=4 and small tone half-periods.
module tb_sound_duration_timer;
    logic       clk = 1'b0;
    logic       reset;
    logic       request_time;
    logic [3:0] time_amount;
    logic [3:0] sound_key;
    logic       time_done;
    logic       busy;
    logic       audio_out;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    sound_duration_timer #(
        .TICK_DIV  (4),
        .HALF_SHOT (3),
        .HALF_HIT  (5),
        .HALF_ENEMY(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .request_time(request_time),
        .time_amount (time_amount),
        .sound_key   (sound_key),
        .time_done   (time_done),
        .busy        (busy),
        .audio_out   (audio_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [3:0] amt);
        request_time = 1'b1;
        time_amount  = amt;
    endtask

    task automatic release_req();
        request_time = 1'b0;
        time_amount  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        request_time = 1'b0;
        time_amount  = '0;
        sound_key    = 4'd15;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", time_done, 0);
        check("rst_audio", audio_out, 0);
        reset = 1'b0;
        tick();

        // Basic duration: request at edge 0, amount 5
        request(4'd5);
        tick();
        release_req();
        for (int i = 1; i <= 20; i++) begin
            check($sformatf("basic_busy_e%0d", i), busy, 1);
            check($sformatf("basic_done_e%0d", i), time_done, 0);
            tick();
        end
        check("basic_done_e21", time_done, 1);
        check("basic_busy_e21", busy, 0);
        tick();
        check("basic_done_e22", time_done, 0);
        repeat (3) tick();

        // Retrigger at edge 10 with amount 2: single pulse at edge 19
        request(4'd5);
        tick();
        release_req();
        repeat (9) tick();
        request(4'd2);
        tick();
        release_req();
        for (int i = 11; i <= 18; i++) begin
            check($sformatf("retrig_busy_e%0d", i), busy, 1);
            check($sformatf("retrig_done_e%0d", i), time_done, 0);
            tick();
        end
        check("retrig_done_e19", time_done, 1);
        for (int i = 20; i <= 25; i++) begin
            tick();
            check($sformatf("retrig_nodone_e%0d", i), time_done, 0);
            check($sformatf("retrig_idle_e%0d", i), busy, 0);
        end
        repeat (2) tick();

        // Zero amount while idle is ignored
        request(4'd0);
        tick();
        release_req();
        check("zero_idle_busy", busy, 0);
        tick();
        check("zero_idle_busy2", busy, 0);
        check("zero_idle_done", time_done, 0);

        // Zero amount at edge 6 aborts the count
        request(4'd5);
        tick();
        release_req();
        repeat (5) tick();
        check("abort_busy_e6", busy, 1);
        request(4'd0);
        tick();
        release_req();
        check("abort_busy_e7", busy, 0);
        for (int i = 8; i <= 30; i++) begin
            tick();
            check($sformatf("abort_done_e%0d", i), time_done, 0);
            check($sformatf("abort_busy_e%0d", i), busy, 0);
        end

        // Request arriving in the S_DONE cycle
        request(4'd1);
        tick();
        release_req();
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("sdone_busy_e%0d", i), busy, 1);
            tick();
        end
        check("sdone_pulse1", time_done, 1);
        request(4'd1);
        tick();
        release_req();
        check("sdone_pulse1_end", time_done, 0);
        for (int i = 6; i <= 9; i++) begin
            check($sformatf("sdone_busy2_e%0d", i), busy, 1);
            tick();
        end
        check("sdone_pulse2", time_done, 1);
        check("sdone_busy_off", busy, 0);
        tick();
        check("sdone_pulse2_end", time_done, 0);
        repeat (2) tick();

        // Tone: key 1 (half period 3) driven after edge 0
        sound_key = 4'd1;
`ifdef TONE_GATE_EN
        for (int i = 1; i <= 12; i++) begin
            tick();
            check($sformatf("gate_audio_e%0d", i), audio_out, 0);
        end
`else
        for (int i = 1; i <= 12; i++) begin
            tick();
            check($sformatf("tone_audio_e%0d", i), audio_out, ((i - 1) / 3) % 2);
        end
`endif
        sound_key = 4'd15;
        for (int i = 13; i <= 16; i++) begin
            tick();
            check($sformatf("silence_audio_e%0d", i), audio_out, 0);
        end

        // Reset mid-count (remaining 3) with key 1 active
        sound_key = 4'd1;
        request(4'd5);
        tick();
        release_req();
        repeat (9) tick();
        #2;
        reset = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", time_done, 0);
        check("midrst_audio", audio_out, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("midrst_hold_busy%0d", i), busy, 0);
            check($sformatf("midrst_hold_audio%0d", i), audio_out, 0);
        end
        @(negedge clk);
        reset = 1'b0;
        sound_key = 4'd15;
        for (int i = 0; i < 30; i++) begin
            tick();
            check($sformatf("postrst_done%0d", i), time_done, 0);
            check($sformatf("postrst_busy%0d", i), busy, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sound_duration_timer.md
Name: sound_duration_timer

Overview:
- Responder side of the audio sound-request interface.
- Accepts a duration request (request_time + time_amount) from the audio modulator FSM and counts it out in coarse time units.
- Returns a single-cycle time_done pulse, which drives the FSM's slowClk input.
- Also turns the FSM's sound_key into a square-wave audio_out for the audio codec path.

Parameters:
- TICK_DIV, 5000000, clk cycles per time unit (100 ms at 50 MHz); must be >= 2.
- HALF_SHOT, 56818, half-period in clk cycles for sound_key 1.
- HALF_HIT, 113636, half-period for sound_key 2.
- HALF_ENEMY, 75757, half-period for sound_key 3.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- request_time  in  1  duration request strobe, sampled each clk
- time_amount  in  4  requested duration in time units, valid with request_time
- sound_key  in  4  1=shot, 2=hit, 3=enemy dead, any other value=silence
- time_done  out  1  one-cycle pulse at the end of the duration
- busy  out  1  high while a duration is being counted
- audio_out  out  1  square-wave tone

Behaviour:
- Reset (asynchronous, active-high; applies to every register):
  - state=S_IDLE, tick_cnt=0, remaining=0, tone_cnt=0, audio_out=0, key_q=15.
  - Outputs time_done=0, busy=0.
- FSM states: S_IDLE, S_COUNT, S_DONE. Outputs are Moore: busy=(state==S_COUNT), time_done=(state==S_DONE).
- S_IDLE:
  - request_time=1 and time_amount!=0: load remaining=time_amount, tick_cnt=0, go to S_COUNT.
  - request_time=1 with time_amount=0: ignored, stay in S_IDLE.
- S_COUNT:
  - tick_cnt increments every clk.
  - At tick_cnt==TICK_DIV-1: tick_cnt wraps to 0 and remaining decrements. If remaining was 1, go to S_DONE.
  - Retrigger: request_time=1 with time_amount!=0 reloads remaining and clears tick_cnt. The old request produces no pulse.
  - Retrigger with time_amount=0 aborts to S_IDLE with no pulse.
  - Retrigger has priority over a same-cycle tick expiry.
- S_DONE:
  - Lasts exactly one cycle, then S_IDLE.
  - A request_time arriving in this cycle is accepted with the S_IDLE rules: the pulse is still emitted and the next state is S_COUNT.
- Latency: request sampled at edge k gives busy high from edge k+1 for N*TICK_DIV cycles (N=time_amount), then time_done high for the single cycle starting at edge k+1+N*TICK_DIV.
- Widths:
  - tick_cnt is $clog2(TICK_DIV) bits.
  - remaining is 4 bits and never underflows; the 0 check happens at load.
  - tone_cnt is 17 bits.
- Tone generator (independent of the FSM):
  - key_q registers sound_key each cycle.
  - On key_q change: tone_cnt=0 and audio_out=0 on the next cycle.
  - Key 1/2/3: tone_cnt counts 0..HALF-1; at HALF-1 it wraps and audio_out toggles. The output period is 2*HALF cycles.
  - Any other key: tone_cnt=0 and audio_out=0.

Optional Feature:
- Macro: TONE_GATE_EN.
- Defined: audio_out is forced to 0, and tone_cnt is held at 0, whenever busy=0. Sound is heard only during a requested duration.
- Undefined: audio_out follows sound_key alone, regardless of busy.

Test Plan:
All scenarios use TICK_DIV=4, HALF_SHOT=3, HALF_HIT=5, HALF_ENEMY=4.
1. Reset:
   - Stimulus: assert reset mid-count (remaining=3) while sound_key=1.
   - Required response: time_done=0, busy=0, audio_out=0 in the same cycle, held until release. After release, no pulse without a new request.
2. Basic duration:
   - Stimulus: request_time=1, time_amount=5 at edge 0.
   - Required response: busy=1 on edges 1..20; time_done=1 only in the cycle starting at edge 21; busy=0 from edge 21.
3. Retrigger:
   - Stimulus: time_amount=5 at edge 0, then request_time=1, time_amount=2 at edge 10.
   - Required response: no pulse at edge 21; a single pulse at edge 19.
4. Zero amount:
   - Stimulus: request_time=1 with time_amount=0, once in S_IDLE and once at edge 6 of an active count.
   - Required response: in S_IDLE, busy stays 0; during the count, the count aborts, busy=0 from edge 7, and no time_done occurs.
5. Request in S_DONE:
   - Stimulus: request_time=1, time_amount=1 in the S_DONE cycle.
   - Required response: time_done is still 1 for that cycle; busy=1 for the next 4 cycles, followed by a second pulse.
6. Tone:
   - Stimulus: sound_key=1 held.
   - Required response: audio_out toggles every 3 cycles (period 6).
   - Stimulus: switch to sound_key=15.
   - Required response: audio_out=0 from the following cycle.
   - With TONE_GATE_EN and busy=0: audio_out stays 0 for sound_key=1.
